// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl
// Read-side scheduler for the ten byte-lane FIFOs behind the BPC/MQ
// lane-rotating writer. Lanes are read strictly in rotation order
// (0..9, wrapping), so the serial output reproduces the writer's byte order.
// The bytes are presented as a ready/valid stream. The block also counts the
// popped bytes per codeblock and pulses flush_done once a flushed codeblock
// has fully drained.
//
// Ports
//   clk_dwt     single clock, rising edge
//   rst         synchronous active-low reset
//   rdempty     per-lane empty flags (lane i = bit i)
//   rd_data     lane read data, lane i = [8i+7:8i]; valid one cycle after rd_req
//   rd_req      one-hot lane read strobe
//   byte_out    serial output byte (0 while byte_vld is low)
//   byte_vld    byte_out valid
//   byte_rdy    downstream ready; pop = byte_vld & byte_rdy
//   flush       end-of-codeblock pulse
//   flush_done  one-cycle pulse when the codeblock has drained
//   lane_ptr    next lane to read, 0..9
//   byte_cnt    saturating count of bytes popped since the last flush_done
//
// state | meaning
// ------+------------------------------------------------------------------
// RUN   | normal streaming; flush loads the wait timer
// FLUSH | timer counts down; leave once timer=0 and every lane and the
//       | output path are empty
// DONE  | flush_done pulse; byte_cnt cleared on exit
module fifo_drain_ctrl #(
   parameter int FLUSH_WAIT = 8,
   parameter int CNT_W      = 16
) (
   input  logic             clk_dwt,
   input  logic             rst,
   input  logic [9:0]       rdempty,
   input  logic [79:0]      rd_data,
   output logic [9:0]       rd_req,
   output logic [7:0]       byte_out,
   output logic             byte_vld,
   input  logic             byte_rdy,
   input  logic             flush,
   output logic             flush_done,
   output logic [3:0]       lane_ptr,
   output logic [CNT_W-1:0] byte_cnt
);

   localparam int WAIT_W = (FLUSH_WAIT < 2) ? 1 : $clog2(FLUSH_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(FLUSH_WAIT);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [3:0]        lane_q, lane_d;
   logic [7:0]        buf_q [2];
   logic              head_q, head_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              infl_q;
   logic [3:0]        infl_lane_q;
   logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;

   logic       pop;
   logic       issue;
   logic [1:0] occ;
   logic       tail;
   logic [7:0] land_byte;

   assign byte_vld = (cnt_q != 2'd0);
   assign pop      = byte_vld & byte_rdy;
   assign occ      = cnt_q + {1'b0, infl_q};

   // A read may only be issued if the byte it returns is guaranteed a
   // buffer slot, counting the pop happening this cycle.
   assign issue    = rst & ~rdempty[lane_q] & ((occ - {1'b0, pop}) < 2'd2);
   assign rd_req   = issue ? (10'd1 << lane_q) : 10'd0;

   // Buffer holds at most 2 entries, and with 2 buffered no read is in
   // flight, so the tail slot is head xor (count is odd).
   assign tail      = head_q ^ cnt_q[0];
   assign land_byte = rd_data[{infl_lane_q, 3'b000} +: 8];

   assign byte_out   = byte_vld ? buf_q[head_q] : 8'h00;
   assign lane_ptr   = lane_q;
   assign byte_cnt   = byte_cnt_q;

   always_comb begin
      lane_d = lane_q;
      if (issue) begin
         lane_d = (lane_q == 4'd9) ? 4'd0 : lane_q + 4'd1;
      end
      cnt_d  = cnt_q + {1'b0, infl_q} - {1'b0, pop};
      head_d = head_q ^ pop;
   end

   always_comb begin
      state_d    = state_q;
      wait_d     = wait_q;
      flush_done = 1'b0;
      byte_cnt_d = byte_cnt_q;
      if (pop && (byte_cnt_q != {CNT_W{1'b1}})) begin
         byte_cnt_d = byte_cnt_q + 1'b1;
      end
      case (state_q)
         ST_RUN: begin
            if (flush) begin
               wait_d  = WAIT_INIT;
               state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (wait_q != '0) begin
               wait_d = wait_q - 1'b1;
            end
            if ((wait_q == '0) && (&rdempty) && (occ == 2'd0) && !issue) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            flush_done = 1'b1;
            byte_cnt_d = '0;
            if (flush) begin
               wait_d  = WAIT_INIT;
               state_d = ST_FLUSH;
            end else begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk_dwt) begin
      if (!rst) begin
         state_q     <= ST_RUN;
         wait_q      <= '0;
         lane_q      <= 4'd0;
         buf_q[0]    <= 8'h00;
         buf_q[1]    <= 8'h00;
         head_q      <= 1'b0;
         cnt_q       <= 2'd0;
         infl_q      <= 1'b0;
         infl_lane_q <= 4'd0;
         byte_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         lane_q      <= lane_d;
         head_q      <= head_d;
         cnt_q       <= cnt_d;
         infl_q      <= issue;
         infl_lane_q <= lane_q;
         byte_cnt_q  <= byte_cnt_d;
         if (infl_q) begin
            buf_q[tail] <= land_byte;
         end
      end
   end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
module tb_fifo_drain_ctrl;

   localparam int FW = 8;
   localparam int CW = 4;

   logic          clk_dwt   = 1'b0;
   logic          rst       = 1'b0;
   logic [9:0]    rdempty;
   logic [79:0]   rd_data_r = '0;
   logic [9:0]    rd_req;
   logic [7:0]    byte_out;
   logic          byte_vld;
   logic          byte_rdy  = 1'b1;
   logic          flush     = 1'b0;
   logic          flush_done;
   logic [3:0]    lane_ptr;
   logic [CW-1:0] byte_cnt;

   logic [7:0] lane_mem [10][64];
   int         wr_ptr [10] = '{default: 0};
   int         rd_ptr [10] = '{default: 0};

   logic [7:0] sb [$];
   int n_checks    = 0;
   int n_errors    = 0;
   int cyc         = 0;
   int outstanding = 0;
   int max_occ     = 0;
   int n_done      = 0;
   int pops_since  = 0;
   int exp_ptr     = 0;

   fifo_drain_ctrl #(.FLUSH_WAIT(FW), .CNT_W(CW)) dut (
      .clk_dwt    (clk_dwt),
      .rst        (rst),
      .rdempty    (rdempty),
      .rd_data    (rd_data_r),
      .rd_req     (rd_req),
      .byte_out   (byte_out),
      .byte_vld   (byte_vld),
      .byte_rdy   (byte_rdy),
      .flush      (flush),
      .flush_done (flush_done),
      .lane_ptr   (lane_ptr),
      .byte_cnt   (byte_cnt)
   );

   always #5 clk_dwt = ~clk_dwt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic push(input int l, input logic [7:0] b, input bit expect_it);
      lane_mem[l][wr_ptr[l] % 64] = b;
      wr_ptr[l]++;
      if (expect_it) sb.push_back(b);
   endtask

   task automatic drain(input int budget);
      int k;
      for (k = 0; k < budget; k++) begin
         @(negedge clk_dwt);
         if (sb.size() == 0 && outstanding == 0) break;
      end
      if (k == budget) chk("drain_timeout", sb.size() + outstanding, 0);
      @(negedge clk_dwt);
   endtask

   task automatic wait_done(output int dc);
      dc = -1;
      for (int k = 0; k < 80; k++) begin
         if (flush_done) begin
            dc = cyc;
            break;
         end
         @(negedge clk_dwt);
      end
      if (dc < 0) chk("flush_done_timeout", flush_done, 1);
   endtask

   // lane FIFO model: data valid the cycle after rd_req, empty flag updates with it
   always_comb begin
      for (int i = 0; i < 10; i++) rdempty[i] = (wr_ptr[i] == rd_ptr[i]);
   end

   always @(posedge clk_dwt) begin
      cyc++;
      for (int i = 0; i < 10; i++) begin
         if (rd_req[i]) begin
            rd_data_r[8*i +: 8] <= lane_mem[i][rd_ptr[i] % 64];
            rd_ptr[i]           <= rd_ptr[i] + 1;
         end
      end
   end

   // scoreboard / protocol monitor
   always @(posedge clk_dwt) begin
      logic [8:0] exp_b;
      if (!rst) begin
         chk("rd_req_in_reset", rd_req, 0);
         sb.delete();
         outstanding = 0;
         exp_ptr     = 0;
         pops_since  = 0;
      end else begin
         if (rd_req != 10'd0) begin
            chk("rd_order", rd_req, 32'd1 << exp_ptr);
            chk("rd_of_empty", rd_req & rdempty, 0);
            exp_ptr = (exp_ptr == 9) ? 0 : exp_ptr + 1;
            outstanding++;
         end
         if (byte_vld && byte_rdy) begin
            exp_b = (sb.size() != 0) ? {1'b0, sb.pop_front()} : 9'h100;
            chk("sb_byte", byte_out, exp_b);
            outstanding--;
            pops_since++;
         end
         if (outstanding > max_occ) max_occ = outstanding;
         if (flush_done) begin
            chk("fd_with_vld", byte_vld, 0);
            n_done++;
            pops_since = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int         f;
      int         dc;
      logic [CW-1:0] cnt0;

      repeat (3) @(negedge clk_dwt);
      chk("rst_vld",      byte_vld,   0);
      chk("rst_out",      byte_out,   0);
      chk("rst_ptr",      lane_ptr,   0);
      chk("rst_cnt",      byte_cnt,   0);
      chk("rst_fd",       flush_done, 0);
      chk("rst_req",      rd_req,     0);
      rst = 1'b1;

      // basic drain
      @(negedge clk_dwt);
      push(0, 8'hA0, 1);
      push(1, 8'hA1, 1);
      push(2, 8'hA2, 1);
      #1 chk("basic_req_c0", rd_req, 10'h001);
      @(negedge clk_dwt);
      chk("basic_req_c1", rd_req, 10'h002);
      chk("basic_vld_c1", byte_vld, 0);
      @(negedge clk_dwt);
      chk("basic_req_c2", rd_req, 10'h004);
      chk("basic_vld_c2", byte_vld, 1);
      chk("basic_out_c2", byte_out, 8'hA0);
      @(negedge clk_dwt);
      chk("basic_out_c3", byte_out, 8'hA1);
      @(negedge clk_dwt);
      chk("basic_out_c4", byte_out, 8'hA2);
      chk("basic_req_c4", rd_req, 0);
      @(negedge clk_dwt);
      chk("basic_vld_c5", byte_vld, 0);
      chk("basic_ptr", lane_ptr, 3);

      // strict order: lane 4 has data, lane 3 empty
      push(4, 8'h55, 0);
      #1 chk("strict_wait0", rd_req, 0);
      for (int i = 1; i < 5; i++) begin
         @(negedge clk_dwt);
         chk("strict_wait", rd_req, 0);
      end
      push(3, 8'h33, 1);
      sb.push_back(8'h55);
      #1 chk("strict_req3", rd_req, 10'h008);
      drain(40);
      chk("strict_ptr", lane_ptr, 5);

      // backpressure
      cnt0 = byte_cnt;
      for (int i = 0; i < 6; i++) push((5 + i) % 10, 8'(8'h60 + i), 1);
      repeat (3) @(negedge clk_dwt);
      byte_rdy = 1'b0;
      repeat (4) @(negedge clk_dwt);
      byte_rdy = 1'b1;
      drain(60);
      chk("bp_occ_max", max_occ, 2);
      chk("bp_cnt", CW'(byte_cnt - cnt0), 6);
      chk("bp_ptr", lane_ptr, 1);

      // wrap 9 -> 0
      for (int l = 1; l < 9; l++) push(l, 8'(8'h10 + l), 1);
      drain(60);
      chk("wrap_ptr9", lane_ptr, 9);
      push(9, 8'h99, 1);
      push(0, 8'h00, 1);
      #1 chk("wrap_req9", rd_req, 10'h200);
      @(negedge clk_dwt);
      chk("wrap_req0", rd_req, 10'h001);
      drain(40);
      chk("wrap_ptr1", lane_ptr, 1);

      // flush with empty path; second flush while waiting must not reload timer
      for (int l = 1; l < 10; l++) push(l, 8'(8'hC0 + l), 1);
      drain(60);
      chk("fl1_ptr0", lane_ptr, 0);
      flush = 1'b1;
      f = cyc;
      @(negedge clk_dwt);
      flush = 1'b0;
      repeat (2) @(negedge clk_dwt);
      flush = 1'b1;
      @(negedge clk_dwt);
      flush = 1'b0;
      wait_done(dc);
      chk("fl1_latency", dc - f, FW + 2);
      chk("fl1_cnt_sat", byte_cnt, (pops_since > 15) ? 15 : pops_since);
      @(negedge clk_dwt);
      chk("fl1_cnt_clr", byte_cnt, 0);
      chk("fl1_fd_one", flush_done, 0);
      chk("fl1_ptr", lane_ptr, 0);

      // flush after 12 bytes
      for (int i = 0; i < 12; i++) push(i % 10, 8'(8'hD0 + i), 1);
      @(negedge clk_dwt);
      flush = 1'b1;
      f = cyc;
      @(negedge clk_dwt);
      flush = 1'b0;
      wait_done(dc);
      chk("fl2_cnt", byte_cnt, 12);
      chk("fl2_all_popped", sb.size(), 0);
      chk("fl2_min_lat", (dc - f) >= FW + 1, 1);
      @(negedge clk_dwt);
      chk("fl2_cnt_clr", byte_cnt, 0);
      chk("fl2_ptr", lane_ptr, 2);
      chk("fl2_fd_one", flush_done, 0);
      repeat (15) @(negedge clk_dwt);
      chk("fl_pulses", n_done, 2);

      // reset with one read in flight and one byte buffered
      byte_rdy = 1'b0;
      for (int i = 0; i < 5; i++) push(2 + i, 8'(8'h20 + i), 0);
      repeat (2) @(negedge clk_dwt);
      rst      = 1'b0;
      byte_rdy = 1'b1;
      push(0, 8'hEE, 0);
      #1 chk("mid_rst_req", rd_req, 0);
      @(negedge clk_dwt);
      chk("mid_rst_vld", byte_vld,   0);
      chk("mid_rst_out", byte_out,   0);
      chk("mid_rst_ptr", lane_ptr,   0);
      chk("mid_rst_cnt", byte_cnt,   0);
      chk("mid_rst_fd",  flush_done, 0);
      rst = 1'b1;
      sb.push_back(8'hEE);
      drain(40);
      repeat (10) @(negedge clk_dwt);
      chk("mid_rst_ptr_after", lane_ptr, 1);
      chk("mid_rst_cnt_after", byte_cnt, 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
